// File: rtl/traffic_lights_pkg.sv
// Shared types for the traffic_lights controller and its command deframer.
// Holds command/error encodings, deframer state and the default sync byte.
package traffic_lights_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    CMD_ON         = 3'd0,
    CMD_OFF        = 3'd1,
    CMD_UNMANAGED  = 3'd2,
    CMD_SET_GREEN  = 3'd3,
    CMD_SET_RED    = 3'd4,
    CMD_SET_YELLOW = 3'd5
  } cmd_type_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CHK     = 2'd1,
    ERR_TYPE    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {
    S_HUNT,
    S_TYPE,
    S_DHI,
    S_DLO,
    S_CHK
  } state_t;

endpackage

// File: rtl/traffic_lights_cmd_deframer_frame_timeout_cnt.sv
// Saturating inter-byte counter; expired is high once count == TICKS.
// Ports: clk, srst (sync, active-high), clr, en, expired.
module frame_timeout_cnt #(
  parameter int TICKS = 1000
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TICKS + 1);
  localparam logic [W-1:0] MAX = W'(TICKS);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != MAX) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (cnt == MAX);

endmodule

// File: rtl/traffic_lights_cmd_deframer.sv
// Finds 5-byte command frames (SYNC,TYPE,DHI,DLO,CHK) and issues commands.
// Ports: clk_i, srst_i, byte_i/byte_valid_i in; cmd_*_o, err_o/err_code_o out.
module traffic_lights_cmd_deframer
  import traffic_lights_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_TICKS = 1000,
  parameter int         MAX_CMD_TYPE  = 5
) (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic [2:0]  cmd_type_o,
  output logic        cmd_valid_o,
  output logic [15:0] cmd_data_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  state_t    state_q, state_d;
  logic [7:0] type_q, type_d;
  logic [7:0] dhi_q, dhi_d;
  logic [7:0] dlo_q, dlo_d;
  cmd_type_t  cmd_type_q, cmd_type_d;
  logic [15:0] cmd_data_q, cmd_data_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       err_q, err_d;
  err_code_t  err_code_q, err_code_d;

  logic expired;
  logic type_bad;

  frame_timeout_cnt #(
    .TICKS(TIMEOUT_TICKS)
  ) u_tmo (
    .clk    (clk_i),
    .srst   (srst_i),
    .clr    ((state_q == S_HUNT) || byte_valid_i),
    .en     (1'b1),
    .expired(expired)
  );

  assign type_bad = (type_q[7:3] != 5'd0)
                 || (int'(type_q[2:0]) > MAX_CMD_TYPE);

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    dhi_d       = dhi_q;
    dlo_d       = dlo_q;
    cmd_type_d  = cmd_type_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    if (byte_valid_i) begin
      unique case (state_q)
        S_HUNT: begin
          if (byte_i == SYNC_BYTE) state_d = S_TYPE;
        end
        S_TYPE: begin
          type_d  = byte_i;
          state_d = S_DHI;
        end
        S_DHI: begin
          dhi_d   = byte_i;
          state_d = S_DLO;
        end
        S_DLO: begin
          dlo_d   = byte_i;
          state_d = S_CHK;
        end
        S_CHK: begin
          state_d = S_HUNT;
          if (byte_i != (type_q ^ dhi_q ^ dlo_q)) begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
          end else if (type_bad) begin
            err_d      = 1'b1;
            err_code_d = ERR_TYPE;
          end else begin
            cmd_valid_d = 1'b1;
            cmd_type_d  = cmd_type_t'(type_q[2:0]);
            cmd_data_d  = {dhi_q, dlo_q};
          end
        end
        default: state_d = S_HUNT;
      endcase
    end else if (expired && state_q != S_HUNT) begin
      // Counter may sit saturated for a cycle in S_HUNT; ignore it there.
      state_d    = S_HUNT;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= S_HUNT;
      type_q      <= '0;
      dhi_q       <= '0;
      dlo_q       <= '0;
      cmd_type_q  <= CMD_ON;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      dhi_q       <= dhi_d;
      dlo_q       <= dlo_d;
      cmd_type_q  <= cmd_type_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign cmd_type_o  = cmd_type_q;
  assign cmd_data_o  = cmd_data_q;
  assign cmd_valid_o = cmd_valid_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

endmodule
